// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: FSM states, default geometry and counter width shared by the DM responder.
package dm_responder_pkg;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH = 256;
  localparam int CNT_WIDTH = 16;
  typedef enum logic [2:0] {S_LOAD, S_START, S_RUN, S_DUMP, S_DONE} state_t;
endpackage

// File: rtl/dm_responder_if.sv
// dm_responder_if: load, processor, dump and status signals of the DM responder.
// DM_PERF_CNT_EN adds the rd_cnt/wr_cnt access counters.
interface dm_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  import dm_responder_pkg::*;
  logic                  ld_valid, ld_ready, ld_last;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  start, stop;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic                  dm_rd, dm_wr;
  logic [DATA_WIDTH-1:0] dm_w_data, dm_r_data;
  logic                  dp_valid, dp_ready, dp_last, done;
  logic [DATA_WIDTH-1:0] dp_data;
  logic [ADDR_WIDTH-1:0] dp_addr;
`ifdef DM_PERF_CNT_EN
  logic [CNT_WIDTH-1:0]  rd_cnt, wr_cnt;
`endif
  modport slave (
    input  ld_valid, ld_data, ld_last, stop, dm_addr, dm_rd, dm_wr, dm_w_data, dp_ready,
    output ld_ready, start, dm_r_data, dp_valid, dp_data, dp_addr, dp_last, done
`ifdef DM_PERF_CNT_EN
    , output rd_cnt, wr_cnt
`endif
  );
  modport master (
    output ld_valid, ld_data, ld_last, stop, dm_addr, dm_rd, dm_wr, dm_w_data, dp_ready,
    input  ld_ready, start, dm_r_data, dp_valid, dp_data, dp_addr, dp_last, done
`ifdef DM_PERF_CNT_EN
    , input rd_cnt, wr_cnt
`endif
  );
endinterface

// File: rtl/dm_responder_sram.sv
// sram_sp: single-port synchronous RAM, read-before-write, rdata updates only on re.
module sram_sp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: loads DM from a host, serves processor reads/writes, then dumps the full image.
// DM_PERF_CNT_EN adds saturating read/write access counters.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic           clk,
  input logic           rst,
  dm_responder_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t                state;
  logic [ADDR_WIDTH-1:0] ld_ptr, dp_ptr, addr;
  logic [DATA_WIDTH-1:0] rdata, wdata, r_hold;
  logic                  rd_pend, ld_hs, go, in_range, run_rd, dp_adv, we, re;
  assign ld_hs    = state == S_LOAD && bus.ld_valid && bus.ld_ready;
  assign go       = ld_hs && (bus.ld_last || ld_ptr == LAST);
  assign in_range = {1'b0, bus.dm_addr} < (ADDR_WIDTH + 1)'(DEPTH);
  assign run_rd   = state == S_RUN && bus.dm_rd;
  // Fetch the next dump word whenever the output slot is empty or being consumed.
  assign dp_adv   = state == S_DUMP && (!bus.dp_valid || (bus.dp_ready && !bus.dp_last));
  assign we       = ld_hs || (state == S_RUN && bus.dm_wr && in_range);
  assign re       = (run_rd && in_range) || dp_adv;
  assign addr     = state == S_LOAD ? ld_ptr : state == S_RUN ? bus.dm_addr : dp_ptr;
  assign wdata    = state == S_LOAD ? bus.ld_data : bus.dm_w_data;
  assign bus.dm_r_data = rd_pend ? rdata : r_hold;
  assign bus.dp_data   = bus.dp_valid ? rdata : '0;
  sram_sp #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .re(re), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_LOAD;
      ld_ptr       <= '0;
      dp_ptr       <= '0;
      rd_pend      <= 1'b0;
      r_hold       <= '0;
      bus.ld_ready <= 1'b0;
      bus.start    <= 1'b0;
      bus.dp_valid <= 1'b0;
      bus.dp_addr  <= '0;
      bus.dp_last  <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      rd_pend   <= run_rd && in_range;
      r_hold    <= (run_rd && !in_range) ? '0 : bus.dm_r_data;
      bus.start <= 1'b0;
      case (state)
        S_LOAD: begin
          bus.ld_ready <= !go;
          if (ld_hs) ld_ptr <= ld_ptr + 1'b1;
          if (go) begin
            state     <= S_START;
            bus.start <= 1'b1;
          end
        end
        S_START: state <= S_RUN;
        S_RUN: if (bus.stop) begin
          state  <= S_DUMP;
          dp_ptr <= '0;
        end
        S_DUMP: if (dp_adv) begin
          dp_ptr       <= dp_ptr + 1'b1;
          bus.dp_valid <= 1'b1;
          bus.dp_addr  <= dp_ptr;
          bus.dp_last  <= dp_ptr == LAST;
        end else if (bus.dp_ready) begin
          state        <= S_DONE;
          bus.dp_valid <= 1'b0;
          bus.dp_last  <= 1'b0;
          bus.done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`ifdef DM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rd_cnt <= '0;
      bus.wr_cnt <= '0;
    end else if (go) begin
      bus.rd_cnt <= '0;
      bus.wr_cnt <= '0;
    end else if (state == S_RUN) begin
      if (bus.dm_rd && !(&bus.rd_cnt)) bus.rd_cnt <= bus.rd_cnt + 1'b1;
      if (bus.dm_wr && !(&bus.wr_cnt)) bus.wr_cnt <= bus.wr_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Synthesizable data-memory responder that answers the pipelined processor's dm_* requests, replacing the behavioural DM model.
- Front end: a host streams initial DM contents in through a valid/ready load port.
- Run phase: the block pulses start, then serves processor reads and writes until stop.
- Back end: it streams the full DM image out on a valid/ready dump port for checking.

Parameters:
ADDR_WIDTH, 8, width of dm_addr and internal pointers
DATA_WIDTH, 16, word width
DEPTH, 256, number of words; must be <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
ld_valid  in  1  host load word valid
ld_ready  out  1  block accepts load word
ld_data  in  DATA_WIDTH  load word, written to address ld_ptr
ld_last  in  1  final load word
start  out  1  one-cycle pulse to processor
stop  in  1  processor finished
dm_addr  in  ADDR_WIDTH  processor access address
dm_rd  in  1  processor read enable
dm_wr  in  1  processor write enable
dm_w_data  in  DATA_WIDTH  processor write data
dm_r_data  out  DATA_WIDTH  registered read data
dp_valid  out  1  dump word valid
dp_ready  in  1  sink accepts dump word
dp_data  out  DATA_WIDTH  dump word
dp_addr  out  ADDR_WIDTH  address of dp_data
dp_last  out  1  marks word DEPTH-1
done  out  1  dump complete

Behaviour:
- Reset values (rst low, asynchronous):
  - Outputs: ld_ready=0, start=0, dm_r_data=0, dp_valid=0, dp_data=0, dp_addr=0, dp_last=0, done=0.
  - State=S_LOAD; ld_ptr=0; dp_ptr=0.
  - Memory contents are not reset. Reset mid-operation returns to S_LOAD and keeps the memory.
- FSM: S_LOAD -> S_START -> S_RUN -> S_DUMP -> S_DONE.
- S_LOAD:
  - ld_ready=1 from the first cycle after reset release.
  - Each ld_valid&ld_ready writes mem[ld_ptr] and increments ld_ptr.
  - Go to S_START after a handshake with ld_last=1, or after the handshake at ld_ptr==DEPTH-1.
  - Unloaded words keep their prior contents.
- S_START: start=1 for exactly one cycle, ld_ready=0, then S_RUN.
- S_RUN:
  - dm_rd=1 at posedge: dm_r_data <= mem[dm_addr], one cycle of latency. dm_r_data holds its value when dm_rd=0.
  - dm_wr=1 at posedge: mem[dm_addr] <= dm_w_data.
  - dm_rd and dm_wr to the same address in one cycle: the write commits and the read returns the old data (read-before-write).
  - dm_addr >= DEPTH: reads return 0 and writes are dropped.
  - stop sampled 1 at posedge: go to S_DUMP with dp_ptr=0. An access presented in the same cycle still completes.
- Outside S_RUN: dm_rd, dm_wr and stop are ignored.
- S_DUMP:
  - Memory read is synchronous, so dp_valid first rises one cycle after entry.
  - dp_data, dp_addr and dp_last are held stable while dp_valid&!dp_ready.
  - On each dp_valid&dp_ready the next word is presented. Back-to-back transfers are supported: with dp_ready held high, one word per cycle after the first.
  - dp_last=1 with dp_addr==DEPTH-1.
  - That final handshake moves to S_DONE.
- S_DONE: done=1, dp_valid=0. Stays here until reset.
- Memory port arbitration is by state (load write, run access, dump read), so a single-port RAM suffices.

Optional Feature:
DM_PERF_CNT_EN
- Defined: adds outputs rd_cnt and wr_cnt, 16 bits each.
  - They count dm_rd and dm_wr cycles accepted in S_RUN, saturating at 16'hFFFF.
  - Cleared by reset and on entry to S_START.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dm_responder_pkg:
  - State encoding (S_LOAD, S_START, S_RUN, S_DUMP, S_DONE).
  - Default ADDR_WIDTH/DATA_WIDTH/DEPTH constants.
  - Counter width constant (16).
- Sub-module sram_sp: single-port synchronous RAM with one address, we, wdata and registered rdata. Top-level muxes address and data by state.

Test Plan:
- Load 25 words ld_data=i+1 with ld_last on word 24 -> single start pulse one cycle after the last handshake; no ld_ready during or after start.
- Run: dm_wr addr0 data 7, then dm_rd addr0 next cycle -> dm_r_data==7 one cycle after the read; stop -> dump word0==7, word1==2, word24==25.
- Same-cycle dm_rd+dm_wr addr3 data 160 over loaded value 4 -> dm_r_data==4; subsequent read returns 160.
- Dump with dp_ready toggling 1,0,0,1 -> no word lost or duplicated; 256 words total; dp_last only on dp_addr==255; done rises after it.
- Assert rst low mid-S_DUMP at dp_addr 10 -> outputs at reset values immediately; reload only word0 with ld_last; run without writes, then stop -> dump word0==new value, words 1..24 retain their earlier values.
- DM_PERF_CNT_EN defined: 3 reads and 2 writes in S_RUN, plus dm_rd pulses in S_LOAD -> rd_cnt==3, wr_cnt==2.
